// File: rtl/glyph_rom_arbiter.sv
// Round-robin arbiter giving four glyph readers shared access to one
// combinational glyph ROM. A transaction is a grant cycle (address
// registered toward the ROM) and then a read cycle (ROM row captured
// into the winner's char register). Requester 0 = fir, 1 = sec,
// 2 = disp_u, 3 = disp_d.
module glyph_rom_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            req,
  input  logic [4*ADDR_W-1:0]   req_addr,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [DATA_W-1:0]     rom_data,
  output logic [3:0]            gnt,
  output logic [3:0]            rd_valid,
  output logic [DATA_W-1:0]     char_fir,
  output logic [DATA_W-1:0]     char_sec,
  output logic [DATA_W-1:0]     char_disp_u,
  output logic [DATA_W-1:0]     char_disp_d,
  output logic                  busy
);

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          last_q, last_d;
  logic [3:0]          gnt_q, gnt_d;
  logic [3:0]          rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [DATA_W-1:0]   char_q [4];
  logic [DATA_W-1:0]   char_d [4];
  logic [1:0]          win;

  // Round-robin pick: first requester found searching upward from last+1,
  // wrapping. Scanning offsets from far to near lets the nearest one win.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  // Next-state and next-output logic for the IDLE/READ transaction sequencer.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    last_d     = last_q;
    gnt_d      = '0;
    rd_valid_d = '0;
    rom_addr_d = rom_addr_q;
    char_d     = char_q;
    win        = rr_pick(req, last_q);
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          rom_addr_d = req_addr[ADDR_W*win +: ADDR_W];
          gnt_d      = 4'b0001 << win;
          last_d     = win;
          state_d    = READ;
        end
      end
      READ: begin
        // last_q holds the winner for the whole transaction; the address was
        // already latched, so later req/req_addr changes cannot disturb it.
        char_d[last_q] = rom_data;
        rd_valid_d     = 4'b0001 << last_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 2'd3;
      gnt_q      <= '0;
      rd_valid_q <= '0;
      rom_addr_q <= '0;
      // NOTE: the char registers are visible outputs that must read zero out
      // of reset, so this small array is reset like any other register.
      for (int i = 0; i < 4; i++) char_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values regardless of statement order.
      state_q    <= state_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      rd_valid_q <= rd_valid_d;
      rom_addr_q <= rom_addr_d;
      for (int i = 0; i < 4; i++) char_q[i] <= char_d[i];
    end
  end

  assign rom_addr    = rom_addr_q;
  assign gnt         = gnt_q;
  assign rd_valid    = rd_valid_q;
  assign char_fir    = char_q[0];
  assign char_sec    = char_q[1];
  assign char_disp_u = char_q[2];
  assign char_disp_d = char_q[3];
  assign busy        = (state_q == READ);

endmodule

// File: tb/tb_glyph_rom_arbiter.sv
// Scoreboard bench for glyph_rom_arbiter: a transaction-level model predicts
// grants and read completions from the sampled requests; a monitor pops and
// compares whenever the DUT presents gnt or rd_valid.
module tb_glyph_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] req_addr;
  logic [3:0]  rom_addr;
  logic [15:0] rom_data;
  logic [3:0]  gnt;
  logic [3:0]  rd_valid;
  logic [15:0] char_fir, char_sec, char_disp_u, char_disp_d;
  logic        busy;

  int n_total = 0;
  int n_pass  = 0;

  logic [15:0] rom [16];
  assign rom_data = rom[rom_addr];

  glyph_rom_arbiter #(.ADDR_W(4), .DATA_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_addr    (req_addr),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .gnt         (gnt),
    .rd_valid    (rd_valid),
    .char_fir    (char_fir),
    .char_sec    (char_sec),
    .char_disp_u (char_disp_u),
    .char_disp_d (char_disp_d),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int idx; } gnt_exp_t;
  typedef struct { int cyc; int idx; logic [3:0][15:0] chars; } rd_exp_t;

  gnt_exp_t gq[$];
  rd_exp_t  rq[$];
  logic [3:0][15:0] ch_m;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Digit-0 glyph; only rows 0 and 3 are fixed, the rest just need to differ.
  initial begin
    rom[0]  = 16'h1FF8; rom[1]  = 16'h3FFC; rom[2]  = 16'h781E; rom[3]  = 16'hE007;
    rom[4]  = 16'hC003; rom[5]  = 16'hC183; rom[6]  = 16'hC3C3; rom[7]  = 16'hC663;
    rom[8]  = 16'hCC33; rom[9]  = 16'hD81B; rom[10] = 16'hF00F; rom[11] = 16'hE00F;
    rom[12] = 16'h701E; rom[13] = 16'h3FF0; rom[14] = 16'h1FE0; rom[15] = 16'h0000;
  end

  // Reference model: one transaction at a time, each taking two edges; the
  // winner is the first active requester after the previous winner.
  initial begin : predictor
    int   pcyc;
    bit   busy_m;
    int   last_m, win_m;
    logic [3:0] addr_m;
    pcyc = 0; busy_m = 0; last_m = 3; win_m = 0; addr_m = '0; ch_m = '0;
    forever begin
      @(posedge clk);
      pcyc++;
      if (rst) begin
        busy_m = 0; last_m = 3; ch_m = '0;
      end else if (busy_m) begin
        ch_m[win_m] = rom[addr_m];
        rq.push_back('{pcyc, win_m, ch_m});
        busy_m = 0;
      end else if (req != 4'b0000) begin
        for (int k = 1; k <= 4; k++) begin
          if (req[(last_m + k) % 4]) begin
            win_m = (last_m + k) % 4;
            break;
          end
        end
        addr_m = req_addr[4*win_m +: 4];
        gq.push_back('{pcyc, win_m});
        last_m = win_m;
        busy_m = 1;
      end
    end
  end

  // Monitor: compares DUT outputs at the falling edge against the queues.
  initial begin : monitor
    int mcyc;
    logic [3:0] eg, er;
    bit have_r;
    gnt_exp_t g;
    rd_exp_t  r;
    mcyc = 0;
    forever begin
      @(negedge clk);
      mcyc++;
      eg = '0;
      if (gq.size() > 0 && gq[0].cyc == mcyc) begin
        g  = gq.pop_front();
        eg = 4'b0001 << g.idx;
      end
      if (gnt != 4'b0000 || eg != 4'b0000) begin
        check("sb_gnt", gnt, eg);
        check("sb_busy_in_grant", busy, (eg != 4'b0000));
      end
      er = '0; have_r = 0;
      if (rq.size() > 0 && rq[0].cyc == mcyc) begin
        r = rq.pop_front();
        er = 4'b0001 << r.idx;
        have_r = 1;
      end
      if (rd_valid != 4'b0000 || have_r) begin
        check("sb_rd_valid", rd_valid, er);
        if (have_r)
          check("sb_chars", {char_disp_d, char_disp_u, char_sec, char_fir}, r.chars);
      end
    end
  end

  // Wait (bounded) until gnt or rd_valid shows a bit in mask; sampled 1 after the edge.
  task automatic wait_for(input bit on_gnt, input logic [3:0] mask, input string name,
                          output logic [3:0] val, output int cycles);
    val = '0; cycles = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (((on_gnt ? gnt : rd_valid) & mask) != 4'b0000) begin
        val = on_gnt ? gnt : rd_valid;
        cycles = n;
        break;
      end
    end
    check({name, "_seen"}, (cycles != 0), 1'b1);
  endtask

  task automatic set_addr(input int i, input logic [3:0] a);
    req_addr[4*i +: 4] = a;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin : stimulus
    logic [3:0] v;
    int cy;
    logic [3:0] sv[$];
    int sc[$];
    rst = 1'b1; req = '0; req_addr = '0;
    #12;
    check("reset_gnt", gnt, 4'b0000);
    check("reset_rd_valid", rd_valid, 4'b0000);
    check("reset_rom_addr", rom_addr, 4'h0);
    check("reset_chars", {char_disp_d, char_disp_u, char_sec, char_fir}, 64'h0);
    check("reset_busy", busy, 1'b0);
    @(posedge clk); #1 rst = 1'b0;

    // Single request from fir, row 0.
    set_addr(0, 4'd0); req = 4'b0001;
    wait_for(1, 4'b1111, "single_gnt", v, cy);
    check("single_gnt_val", v, 4'b0001);
    check("single_gnt_latency", cy, 1);
    wait_for(0, 4'b1111, "single_rd", v, cy);
    req = 4'b0000;
    check("single_rd_val", v, 4'b0001);
    check("single_rd_latency", cy, 1);
    check("single_char_fir", char_fir, 16'h1FF8);
    check("single_other_chars", {char_disp_d, char_disp_u, char_sec}, 48'h0);

    // Contention: all four held, requester 0 first after reset.
    pulse_reset();
    req_addr = {4'd3, 4'd3, 4'd0, 4'd3};
    req = 4'b1111;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      if (rd_valid != 4'b0000) begin
        sv.push_back(rd_valid);
        sc.push_back(i);
      end
    end
    req = 4'b0000;
    check("contend_count", sv.size(), 8);
    for (int i = 0; i < sv.size() && i < 8; i++) begin
      check("contend_order", sv[i], 4'b0001 << (i % 4));
      if (i > 0) check("contend_spacing", sc[i] - sc[i-1], 2);
    end
    check("contend_char_fir", char_fir, 16'hE007);
    check("contend_char_sec", char_sec, 16'h1FF8);
    check("contend_char_disp_u", char_disp_u, 16'hE007);
    check("contend_char_disp_d", char_disp_d, 16'hE007);

    // Fairness: after serving 2, requester 0 goes before 2 again.
    set_addr(2, 4'd5); req = 4'b0100;
    wait_for(0, 4'b0100, "fair_first", v, cy);
    req = 4'b0101;
    wait_for(0, 4'b1111, "fair_next", v, cy);
    check("fair_next_is_fir", v, 4'b0001);
    req = 4'b0100;
    wait_for(0, 4'b0100, "fair_then_disp_u", v, cy);
    req = 4'b0000;

    // Address change after grant must not affect the read.
    set_addr(2, 4'd0); req = 4'b0100;
    wait_for(0, 4'b0100, "addr_pre", v, cy);
    req = 4'b0000;
    check("addr_pre_char", char_disp_u, 16'h1FF8);
    set_addr(2, 4'd3); req = 4'b0100;
    wait_for(1, 4'b0100, "addr_gnt", v, cy);
    set_addr(2, 4'd0);
    wait_for(0, 4'b0100, "addr_rd", v, cy);
    req = 4'b0000;
    check("addr_change_char", char_disp_u, 16'hE007);

    // Reset during READ: no completion, outputs cleared, lowest index wins next.
    set_addr(1, 4'd7); set_addr(3, 4'd9); req = 4'b1010;
    wait_for(1, 4'b1111, "rstmid_gnt", v, cy);
    @(negedge clk); #1 rst = 1'b1;
    #1;
    check("rstmid_outputs", {gnt, rd_valid, rom_addr, busy}, 13'h0);
    check("rstmid_chars", {char_disp_d, char_disp_u, char_sec, char_fir}, 64'h0);
    @(posedge clk); #1;
    check("rstmid_no_rd_valid", rd_valid, 4'b0000);
    rst = 1'b0;
    wait_for(1, 4'b1111, "rstmid_regnt", v, cy);
    check("rstmid_regnt_val", v, 4'b0010);
    check("rstmid_regnt_latency", cy, 1);
    wait_for(0, 4'b1111, "rstmid_rd", v, cy);
    req = 4'b0000;
    check("rstmid_char_sec", char_sec, 16'hC663);

    // Idle for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("idle_quiet", {gnt, rd_valid, busy}, 9'h0);
      check("idle_chars", {char_disp_d, char_disp_u, char_sec, char_fir}, ch_m);
    end

    // Random requests and addresses every cycle.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      req      = 4'($urandom);
      req_addr = 16'($urandom);
    end
    req = 4'b0000;
    repeat (4) @(posedge clk);
    #1;
    check("gnt_queue_drained", gq.size(), 0);
    check("rd_queue_drained", rq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/glyph_rom_arbiter.md
GLYPH_ROM_ARBITER -- requirements
Module: glyph_rom_arbiter

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, 4, glyph row address width.
- DATA_W, 16, glyph row width.
REQ-002 clk  input  1  system clock; all state SHALL change on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req  input  4  per-requester read request; bit 0 = fir, bit 1 = sec, bit 2 = disp_u, bit 3 = disp_d.
REQ-005 req_addr  input  4*ADDR_W  packed row addresses; requester i SHALL use bits [4i+3:4i].
REQ-006 rom_addr  output  ADDR_W  registered address driven to the shared combinational glyph ROM.
REQ-007 rom_data  input  DATA_W  ROM row data; combinational from rom_addr.
REQ-008 gnt  output  4  one-hot, registered; high for exactly one cycle when a requester wins.
REQ-009 rd_valid  output  4  one-hot, registered; high for exactly one cycle when that requester's data register updates.
REQ-010 char_fir, char_sec, char_disp_u, char_disp_d  output  DATA_W each  per-requester held row data.
REQ-011 busy  output  1  high while state = READ.

Function
REQ-012 The FSM SHALL have two states, IDLE and READ.
REQ-013 IDLE, with req != 0:
- select winner W by round-robin, searching from (last_winner+1) mod 4 upward with wrap;
- register rom_addr <= req_addr[W], gnt <= onehot(W), last_winner <= W;
- go to READ.
REQ-014 IDLE, with req == 0: SHALL stay in IDLE; gnt and rom_addr SHALL hold (gnt = 0).
REQ-015 READ, on the next edge:
- capture rom_data into the char register of W;
- rd_valid <= onehot(W), gnt <= 0;
- return to IDLE.
REQ-016 READ SHALL NOT arbitrate, so at most one transaction completes every 2 cycles.
REQ-017 Latency: req sampled high at edge k with IDLE and no contention SHALL give gnt high after edge k and rd_valid plus updated char after edge k+1.
REQ-018 Requesters SHALL hold req and addr until rd_valid.
- Changes to req_addr after the grant edge SHALL NOT affect the transaction.
- req deasserting during READ SHALL NOT abort the transaction.
REQ-019 req still high in the rd_valid cycle SHALL be treated as a new request at the next IDLE arbitration.
REQ-020 Char registers of non-winning requesters SHALL hold their values; a char register changes only with its rd_valid.
REQ-021 With all four requesting continuously, service order SHALL rotate 0,1,2,3,0,…, each served once per 8 cycles; no requester SHALL starve.
REQ-022 gnt and rd_valid SHALL never have more than one bit set, and SHALL never be set in the same cycle.

Reset
REQ-023 rst high SHALL immediately, regardless of clk:
- set state = IDLE;
- clear gnt, rd_valid, rom_addr and all four char registers;
- set last_winner = 3, so requester 0 has top priority.
REQ-024 Reset during READ SHALL abandon the transaction with no rd_valid pulse; the requester SHALL re-request.
REQ-025 The first rising edge after rst falls SHALL perform normal IDLE arbitration.

Verification (ROM loaded with digit-0 glyph: row0 = 16'h1FF8, row3 = 16'hE007)
REQ-026 Single request:
- stimulus: req = 4'b0001, addr_fir = 0;
- response: gnt = 0001 one cycle, then rd_valid = 0001, char_fir = 1FF8; other chars remain 0.
REQ-027 Contention:
- stimulus: req = 4'b1111 held; all addr = 3 except addr_sec = 0;
- response: rd_valid order 0001, 0010, 0100, 1000 on alternate cycles; char_sec = 1FF8; others = E007.
REQ-028 Round-robin fairness:
- stimulus: after serving requester 2, assert req = 4'b0101;
- response: requester 0 is served before requester 2 is served again.
REQ-029 Address change after grant:
- stimulus: addr_disp_u changes from 3 to 0 in the READ cycle;
- response: char_disp_u = E007.
REQ-030 Reset mid-READ:
- stimulus: assert rst in the READ cycle;
- response: no rd_valid pulse; all outputs 0; first grant after release goes to the lowest-index active requester.
REQ-031 Idle:
- stimulus: req = 0 for 20 cycles;
- response: gnt = 0, rd_valid = 0, busy = 0, char registers unchanged.
